// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_VALID
  } arb_state_t;

  localparam int GRANT_W = 8;
  localparam logic [GRANT_W-1:0] WRITE_GRANT = '1;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// Combinational round-robin picker: first request at or after ptr_i.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the download writer and
// NUM_PORTS round-robin read requesters, one transaction in flight.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            wr_req,
  output logic                            wr_ack,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_PORTS-1:0]            rd_req,
  output logic [NUM_PORTS-1:0]            rd_ack,
  output logic [NUM_PORTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_q,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [DATA_WIDTH-1:0]           sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [DATA_WIDTH-1:0]           sdram_q
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t             state_q;
  logic [GRANT_W-1:0]     grant_q;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   we_q;
  logic                   req_q;
  logic                   wr_ack_q;
  logic [NUM_PORTS-1:0]   rd_ack_q;
  logic [NUM_PORTS-1:0]   rd_valid_q;
  logic [DATA_WIDTH-1:0]  rd_q_q;

  logic [NUM_PORTS-1:0]   rd_req_eff;
  logic                   wr_req_eff;
  logic [NUM_PORTS-1:0]   rd_gnt;
  logic [IW-1:0]          rd_idx;
  logic                   rd_any;
  logic [ADDR_WIDTH-1:0]  rd_addr_sel;
  logic [NUM_PORTS-1:0]   grant_oh;

  // A requester still sees its own ack this cycle; do not re-grant it yet.
  assign rd_req_eff = rd_req & ~rd_ack_q;
  assign wr_req_eff = wr_req & ~wr_ack_q;

  rr_select #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req_i (rd_req_eff),
    .ptr_i (ptr_q),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  always_comb begin
    rd_addr_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_addr_sel |= rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]
                   & {ADDR_WIDTH{rd_gnt[i]}};
    end
  end

  assign ptr_d    = (rd_idx == IW'(NUM_PORTS - 1)) ? '0 : rd_idx + 1'b1;
  assign grant_oh = NUM_PORTS'(1) << grant_q[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= '0;
      rd_valid_q <= '0;
      rd_q_q     <= '0;
    end else begin
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= '0;
      rd_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (wr_req_eff) begin
            grant_q <= WRITE_GRANT;
            addr_q  <= wr_addr;
            data_q  <= wr_data;
            we_q    <= 1'b1;
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end else if (rd_any) begin
            grant_q <= GRANT_W'(rd_idx);
            ptr_q   <= ptr_d;
            addr_q  <= rd_addr_sel;
            data_q  <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_q <= 1'b0;
            if (grant_q == WRITE_GRANT) begin
              wr_ack_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              rd_ack_q <= grant_oh;
              state_q  <= WAIT_VALID;
            end
          end
        end
        WAIT_VALID: begin
          if (sdram_valid) begin
            rd_q_q     <= sdram_q;
            rd_valid_q <= grant_oh;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;
  assign rd_valid   = rd_valid_q;
  assign rd_q       = rd_q_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_we   = we_q;
  assign sdram_req  = req_q;

  a_one_pulse: assert property (@(posedge clk) disable iff (reset)
    $onehot0({wr_ack, rd_ack, rd_valid}));

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    sdram_req && !sdram_ack |=> sdram_req);

endmodule
